// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_if
// Description : Write/read handshake bundle for sync_fifo. The master modport
//               is the user side (producer + consumer); the slave modport is
//               the FIFO itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 2
);
  // Write side
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             awfull;
  // Read side
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             arempty;

  modport master (
    output winc,
    output wdata,
    input  wfull,
    input  awfull,
    output rinc,
    input  rdata,
    input  rempty,
    input  arempty
  );

  modport slave (
    input  winc,
    input  wdata,
    output wfull,
    output awfull,
    input  rinc,
    output rdata,
    output rempty,
    output arempty
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ram
// Description : DSIZE x 2^ASIZE storage array with a synchronous write port
//               and an asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ram #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 2
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic [ASIZE-1:0] waddr,
  input  wire logic [DSIZE-1:0] wdata,
  input  wire logic [ASIZE-1:0] raddr,
  output logic      [DSIZE-1:0] rdata
);

  localparam int c_DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] r_mem [c_DEPTH];

  // Write port: store the word on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read port is asynchronous so the head word falls through immediately
  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO, 2^ASIZE words of
//               DSIZE bits, with full/empty and almost-full/almost-empty
//               flags decoded from a registered occupancy counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 2
) (
  input wire logic  clk,
  input wire logic  rst,
  sync_fifo_if.slave bus
);

  // Occupancy thresholds, sized to the counter (ASIZE+1 bits)
  localparam logic [ASIZE:0] c_DEPTH    = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] c_DEPTH_M1 = {1'b0, {ASIZE{1'b1}}};
  localparam logic [ASIZE:0] c_ONE      = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] c_ZERO     = '0;

  logic [ASIZE-1:0] r_wptr;
  logic [ASIZE-1:0] r_rptr;
  logic [ASIZE:0]   r_cnt;
  logic             w_wr_en;
  logic             w_rd_en;

  // Requests are qualified by the flags of the current cycle, so a write
  // while full or a read while empty is discarded regardless of the other
  // side's activity.
  assign w_wr_en = bus.winc && !bus.wfull;
  assign w_rd_en = bus.rinc && !bus.rempty;

  // Pointer and occupancy update; reset discards every stored word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= r_wptr + ASIZE'(1);
      end
      if (w_rd_en) begin
        r_rptr <= r_rptr + ASIZE'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_cnt <= r_cnt + c_ONE;
        2'b01:   r_cnt <= r_cnt - c_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Flags come straight from the registered count: no extra latency
  assign bus.wfull   = (r_cnt == c_DEPTH);
  assign bus.awfull  = (r_cnt >= c_DEPTH_M1);
  assign bus.rempty  = (r_cnt == c_ZERO);
  assign bus.arempty = (r_cnt <= c_ONE);

  sync_fifo_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_ram (
    .clk   (clk),
    .we    (w_wr_en),
    .waddr (r_wptr),
    .wdata (bus.wdata),
    .raddr (r_rptr),
    .rdata (bus.rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo (DSIZE=32, ASIZE=2) with a
//               queue-based reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  localparam int DSIZE = 32;
  localparam int ASIZE = 2;
  localparam int DEPTH = 1 << ASIZE;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [DSIZE-1:0] q[$];

  sync_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

  sync_fifo #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one clock; the model applies the operations the FIFO should
  // accept at this edge, then outputs are sampled 1 time unit later.
  task automatic tick();
    bit acc_w;
    bit acc_r;
    if (rst) begin
      q.delete();
    end else begin
      acc_w = bus.winc && (q.size() < DEPTH);
      acc_r = bus.rinc && (q.size() != 0);
      if (acc_r) void'(q.pop_front());
      if (acc_w) q.push_back(bus.wdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.winc = 1'b1; bus.rinc = 1'b1; bus.wdata = 32'hDEADBEEF;
    tick(); tick();
    rst = 1'b0; idle_inputs();
    n_checks++; if (bus.rempty !== 1'b1) begin n_errors++; $display("FAIL reset_rempty got=%b exp=1", bus.rempty); end
    n_checks++; if (bus.arempty !== 1'b1) begin n_errors++; $display("FAIL reset_arempty got=%b exp=1", bus.arempty); end
    n_checks++; if (bus.wfull !== 1'b0) begin n_errors++; $display("FAIL reset_wfull got=%b exp=0", bus.wfull); end
    n_checks++; if (bus.awfull !== 1'b0) begin n_errors++; $display("FAIL reset_awfull got=%b exp=0", bus.awfull); end
    tick();
    n_checks++; if (bus.rempty !== 1'b1) begin n_errors++; $display("FAIL reset_nothing_stored rempty got=%b exp=1", bus.rempty); end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 4; k++) begin
      bus.winc = 1'b1; bus.wdata = 32'h11111111 * k;
      tick();
      n_checks++; if (bus.rempty !== 1'b0) begin n_errors++; $display("FAIL fill%0d_rempty got=%b exp=0", k, bus.rempty); end
      n_checks++; if (bus.arempty !== (k <= 1)) begin n_errors++; $display("FAIL fill%0d_arempty got=%b exp=%b", k, bus.arempty, (k <= 1)); end
      n_checks++; if (bus.awfull !== (k >= 3)) begin n_errors++; $display("FAIL fill%0d_awfull got=%b exp=%b", k, bus.awfull, (k >= 3)); end
      n_checks++; if (bus.wfull !== (k == 4)) begin n_errors++; $display("FAIL fill%0d_wfull got=%b exp=%b", k, bus.wfull, (k == 4)); end
    end
    bus.wdata = 32'h55555555;
    tick();
    idle_inputs();
    n_checks++; if (bus.wfull !== 1'b1) begin n_errors++; $display("FAIL overflow_wfull got=%b exp=1", bus.wfull); end
    n_checks++; if (bus.rdata !== 32'h11111111) begin n_errors++; $display("FAIL overflow_head got=%h exp=11111111", bus.rdata); end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (bus.rdata !== 32'h11111111 * k) begin n_errors++; $display("FAIL drain%0d_rdata got=%h exp=%h", k, bus.rdata, 32'h11111111 * k); end
      bus.rinc = 1'b1;
      tick();
    end
    n_checks++; if (bus.rempty !== 1'b1) begin n_errors++; $display("FAIL drain_rempty got=%b exp=1", bus.rempty); end
    tick();
    bus.rinc = 1'b0;
    n_checks++; if ({bus.rempty, bus.arempty, bus.awfull, bus.wfull} !== 4'b1100) begin n_errors++; $display("FAIL underflow_flags got=%b exp=1100", {bus.rempty, bus.arempty, bus.awfull, bus.wfull}); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      bus.winc = 1'b1; bus.wdata = i;
      tick();
      bus.winc = 1'b0;
      n_checks++; if (bus.rdata !== 32'(i)) begin n_errors++; $display("FAIL wrap%0d_rdata got=%h exp=%h", i, bus.rdata, 32'(i)); end
      bus.rinc = 1'b1;
      tick();
      bus.rinc = 1'b0;
      n_checks++; if (bus.rempty !== 1'b1) begin n_errors++; $display("FAIL wrap%0d_rempty got=%b exp=1", i, bus.rempty); end
    end
  endtask

  task automatic test_simultaneous();
    logic [DSIZE-1:0] order [7];
    order[0] = 32'hA0000000; order[1] = 32'hA0000001;
    for (int j = 0; j < 5; j++) order[j+2] = 32'hC0000000 + j;
    bus.winc = 1'b1;
    bus.wdata = order[0]; tick();
    bus.wdata = order[1]; tick();
    bus.rinc = 1'b1;
    for (int j = 0; j < 5; j++) begin
      bus.wdata = order[j+2];
      n_checks++; if (bus.rdata !== order[j]) begin n_errors++; $display("FAIL simul%0d_rdata got=%h exp=%h", j, bus.rdata, order[j]); end
      tick();
      n_checks++; if ({bus.rempty, bus.arempty, bus.awfull, bus.wfull} !== 4'b0000) begin n_errors++; $display("FAIL simul%0d_flags got=%b exp=0000", j, {bus.rempty, bus.arempty, bus.awfull, bus.wfull}); end
    end
    bus.winc = 1'b0;
    for (int j = 5; j < 7; j++) begin
      n_checks++; if (bus.rdata !== order[j]) begin n_errors++; $display("FAIL simul_tail%0d_rdata got=%h exp=%h", j, bus.rdata, order[j]); end
      tick();
    end
    bus.rinc = 1'b0;
    // Empty: the write wins, the read is ignored
    bus.winc = 1'b1; bus.rinc = 1'b1; bus.wdata = 32'hE0E0E0E0;
    tick();
    idle_inputs();
    n_checks++; if (bus.rempty !== 1'b0) begin n_errors++; $display("FAIL empty_wr_rd_rempty got=%b exp=0", bus.rempty); end
    n_checks++; if (bus.rdata !== 32'hE0E0E0E0) begin n_errors++; $display("FAIL empty_wr_rd_rdata got=%h exp=E0E0E0E0", bus.rdata); end
    bus.rinc = 1'b1; tick(); bus.rinc = 1'b0;
    // Full: the read wins, the write is dropped
    bus.winc = 1'b1;
    for (int j = 1; j <= 4; j++) begin bus.wdata = 32'hF0 + j; tick(); end
    bus.rinc = 1'b1; bus.wdata = 32'hBAD0BAD0;
    tick();
    idle_inputs();
    n_checks++; if (bus.wfull !== 1'b0) begin n_errors++; $display("FAIL full_wr_rd_wfull got=%b exp=0", bus.wfull); end
    n_checks++; if (bus.awfull !== 1'b1) begin n_errors++; $display("FAIL full_wr_rd_awfull got=%b exp=1", bus.awfull); end
    for (int j = 2; j <= 4; j++) begin
      n_checks++; if (bus.rdata !== 32'hF0 + j) begin n_errors++; $display("FAIL full_wr_rd_drain%0d got=%h exp=%h", j, bus.rdata, 32'hF0 + j); end
      bus.rinc = 1'b1; tick(); bus.rinc = 1'b0;
    end
    n_checks++; if (bus.rempty !== 1'b1) begin n_errors++; $display("FAIL full_wr_rd_dropped rempty got=%b exp=1", bus.rempty); end
  endtask

  task automatic test_mid_reset();
    bus.winc = 1'b1;
    for (int j = 0; j < 3; j++) begin bus.wdata = 32'h77000000 + j; tick(); end
    bus.winc = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (bus.rempty !== 1'b1) begin n_errors++; $display("FAIL midrst_rempty got=%b exp=1", bus.rempty); end
    bus.winc = 1'b1; bus.wdata = 32'hA5A5A5A5; tick(); bus.winc = 1'b0;
    n_checks++; if (bus.rdata !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL midrst_first_word got=%h exp=A5A5A5A5", bus.rdata); end
    bus.rinc = 1'b1; tick(); bus.rinc = 1'b0;
    n_checks++; if (bus.rempty !== 1'b1) begin n_errors++; $display("FAIL midrst_after_read rempty got=%b exp=1", bus.rempty); end
  endtask

  task automatic test_random();
    int sz;
    for (int n = 0; n < 400; n++) begin
      bus.winc  = ($urandom_range(0, 99) < 55);
      bus.rinc  = ($urandom_range(0, 99) < 50);
      bus.wdata = $urandom;
      rst       = ($urandom_range(0, 63) == 0);
      if (q.size() != 0) begin
        n_checks++; if (bus.rdata !== q[0]) begin n_errors++; $display("FAIL rand%0d_rdata got=%h exp=%h", n, bus.rdata, q[0]); end
      end
      tick();
      sz = q.size();
      n_checks++;
      if ({bus.rempty, bus.arempty, bus.awfull, bus.wfull} !==
          {(sz == 0), (sz <= 1), (sz >= DEPTH - 1), (sz == DEPTH)}) begin
        n_errors++;
        $display("FAIL rand%0d_flags got=%b exp=%b occupancy=%0d", n,
                 {bus.rempty, bus.arempty, bus.awfull, bus.wfull},
                 {(sz == 0), (sz <= 1), (sz >= DEPTH - 1), (sz == DEPTH)}, sz);
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
